// File: rtl/ddr_data_path_gen2.sv
// ddr_data_path_gen2: single-clock DDR data path (write burst sequencer + read aligner)
//
// Ports:
//   CLK100, RESET_N          system clock, asynchronous active-low reset
//   SC_CL[2:0]               CAS latency, [2:1] integer part (2 or 3), [0] half cycle
//   WR_REQ / WR_NEXT         write command in, word pop out (WR_DATA/WR_DM sampled on WR_NEXT)
//   WR_DATA, WR_DM           {fall, rise} write word and byte masks
//   RD_REQ                   read command in
//   RD_DATA/RD_VALID/RD_LAST aligned {beat1, beat0} read words
//   ERR                      one-cycle pulse on an illegal request
//   DQ_OUT_*/DM_OUT_*/DQ_OE  write data, masks and tristate enable to the I/O cells
//   DQS_OUT_*/DQS_OE         strobe levels and tristate enable
//   DQ_IN_R, DQ_IN_F         captured read data from the I/O cells
// Optional feature macro DDR_DP_STATS_EN adds STATS_CLR, WR_BURSTS and RD_BURSTS.
module ddr_data_path_gen2 #(
    parameter int DQ_W    = 16,
    parameter int DM_W    = DQ_W / 8,
    parameter int BL      = 4,
    parameter int CAP_LAT = 1
) (
    input  logic              CLK100,
    input  logic              RESET_N,
    input  logic [2:0]        SC_CL,
    input  logic              WR_REQ,
    output logic              WR_NEXT,
    input  logic [2*DQ_W-1:0] WR_DATA,
    input  logic [2*DM_W-1:0] WR_DM,
    input  logic              RD_REQ,
    output logic [2*DQ_W-1:0] RD_DATA,
    output logic              RD_VALID,
    output logic              RD_LAST,
    output logic              ERR,
    output logic [DQ_W-1:0]   DQ_OUT_R,
    output logic [DQ_W-1:0]   DQ_OUT_F,
    output logic [DM_W-1:0]   DM_OUT_R,
    output logic [DM_W-1:0]   DM_OUT_F,
    output logic              DQ_OE,
    output logic [DM_W-1:0]   DQS_OUT_R,
    output logic [DM_W-1:0]   DQS_OUT_F,
    output logic              DQS_OE,
`ifdef DDR_DP_STATS_EN
    input  logic              STATS_CLR,
    output logic [15:0]       WR_BURSTS,
    output logic [15:0]       RD_BURSTS,
`endif
    input  logic [DQ_W-1:0]   DQ_IN_R,
    input  logic [DQ_W-1:0]   DQ_IN_F
);
    localparam int H  = BL / 2;
    localparam int BW = (H > 1) ? $clog2(H) : 1;
    localparam int N  = 3 + CAP_LAT + H;
    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_PRE   = 2'd1;
    localparam logic [1:0] W_BURST = 2'd2;
    localparam logic [1:0] W_POST  = 2'd3;
    localparam logic [BW-1:0] B_LAST = BW'(H - 1);
    localparam logic [N-1:0] H_MASK = N'((1 << H) - 1);
    localparam logic [N-1:0] ONE    = N'(1);

    logic [1:0]      st, st_nxt;
    logic [BW-1:0]   b, pi;
    logic            cont, b_last, last_pop, wr_acc, rd_acc;
    logic [3:0]      rc;
    logic [7:0]      j;
    logic [N-1:0]    sv, sl, sh, ins, ins_last;
    logic [DQ_W-1:0] r_q, f_q;

    // pi is the index of the word popped this cycle; a pop of the final word
    // of a burst is the only point where a new write can chain without a gap
    always_comb begin
        b_last   = b == B_LAST;
        pi       = (st == W_BURST && !b_last) ? b + 1'b1 : '0;
        WR_NEXT  = st == W_PRE || (st == W_BURST && (!b_last || cont));
        last_pop = WR_NEXT && pi == B_LAST;
        wr_acc   = WR_REQ && (st == W_IDLE || last_pop);
        rd_acc   = RD_REQ && !WR_REQ && st == W_IDLE && rc >= 4'(H);
        st_nxt   = (st == W_IDLE)  ? (wr_acc ? W_PRE : W_IDLE) :
                   (st == W_PRE)   ? W_BURST :
                   (st == W_BURST) ? ((b_last && !cont) ? W_POST : W_BURST) : W_IDLE;
        // tags land at depth j so tag k reaches stage 0 one cycle after its data pair is captured
        j        = (SC_CL[2:1] == 2'd3 ? 8'd3 : 8'd2) + 8'(CAP_LAT);
        ins      = H_MASK << j;
        ins_last = ONE << (j + 8'(H - 1));
    end

    assign DQ_OE     = st == W_BURST;
    assign DQS_OE    = st != W_IDLE;
    assign DQS_OUT_R = {DM_W{st == W_BURST}};
    assign DQS_OUT_F = '0;

    always_ff @(posedge CLK100 or negedge RESET_N) begin
        if (!RESET_N) begin
            st       <= W_IDLE;
            b        <= '0;
            cont     <= 1'b0;
            ERR      <= 1'b0;
            DQ_OUT_R <= '0;
            DQ_OUT_F <= '0;
            DM_OUT_R <= '0;
            DM_OUT_F <= '0;
            rc       <= 4'(H);
            sv       <= '0;
            sl       <= '0;
            sh       <= '0;
            r_q      <= '0;
            f_q      <= '0;
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            st   <= st_nxt;
            b    <= (st == W_BURST && !b_last) ? b + 1'b1 : '0;
            cont <= (wr_acc && st != W_IDLE) || (cont && !(st == W_BURST && b_last));
            ERR  <= (WR_REQ && !wr_acc) || (RD_REQ && !rd_acc);
            if (WR_NEXT) begin
                DQ_OUT_R <= WR_DATA[DQ_W-1:0];
                DQ_OUT_F <= WR_DATA[2*DQ_W-1:DQ_W];
                DM_OUT_R <= WR_DM[DM_W-1:0];
                DM_OUT_F <= WR_DM[2*DM_W-1:DM_W];
            end
            rc  <= rd_acc ? 4'd1 : (rc < 4'(H) ? rc + 4'd1 : rc);
            sv  <= (sv >> 1) | (rd_acc ? ins : '0);
            sl  <= (sl >> 1) | (rd_acc ? ins_last : '0);
            sh  <= (sh >> 1) | (rd_acc ? (ins & {N{SC_CL[0]}}) : '0);
            r_q <= DQ_IN_R;
            f_q <= DQ_IN_F;
            RD_VALID <= sv[0];
            RD_LAST  <= sv[0] & sl[0];
            // half-cycle CL: beat0 came on F last cycle, beat1 is on R now
            if (sv[0])
                RD_DATA <= sh[0] ? {DQ_IN_R, f_q} : {f_q, r_q};
        end
    end

`ifdef DDR_DP_STATS_EN
    always_ff @(posedge CLK100 or negedge RESET_N) begin
        if (!RESET_N) begin
            WR_BURSTS <= '0;
            RD_BURSTS <= '0;
        end else if (STATS_CLR) begin
            WR_BURSTS <= '0;
            RD_BURSTS <= '0;
        end else begin
            if (wr_acc && WR_BURSTS != 16'hFFFF)
                WR_BURSTS <= WR_BURSTS + 16'd1;
            if (RD_LAST && RD_BURSTS != 16'hFFFF)
                RD_BURSTS <= RD_BURSTS + 16'd1;
        end
    end
`endif
endmodule
